udma_tx_dp_unpacker: RTL and testbench

// Peripheral-side receiving end of the uDMA TX datapath: the counterpart of the RX datapath that packs

---
 rtl/udma_tx_dp_unpacker.sv | 141 ++++++++++++++
 tb/tb_udma_tx_dp_unpacker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_tx_dp_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : udma_tx_dp_unpacker
// Brief    : Credit-based uDMA TX word receiver with a word FIFO and an
//            LSB-first byte unpacker feeding the peripheral serializer.
// Revision : 1.0 - initial release
// ============================================================================
module udma_tx_dp_unpacker #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          cfg_en_i,
    input  logic [1:0]    cfg_datasize_i,
    output logic          data_tx_req_o,
    input  logic          data_tx_gnt_i,
    output logic [1:0]    data_tx_datasize_o,
    input  logic [DW-1:0] data_tx_i,
    input  logic          data_tx_valid_i,
    output logic          data_tx_ready_o,
    output logic [7:0]    byte_o,
    output logic          byte_valid_o,
    input  logic          byte_ready_i,
    output logic          busy_o,
    output logic          err_o
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_cnt_w:0]   c_depth    = (c_cnt_w + 1)'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [c_cnt_w-1:0] r_pending;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [1:0]         r_byte_idx;
    logic               r_err;
    logic [DW-1:0]      r_mem [DEPTH];
    logic [1:0]         r_tag [DEPTH];

    logic [c_cnt_w:0]   w_outstanding;
    logic               w_grant;
    logic               w_accept;
    logic               w_drop;
    logic               w_byte_take;
    logic               w_last_byte;
    logic               w_pop;
    logic [1:0]         w_tag_in;
    logic [1:0]         w_last_idx;
    logic [DW-1:0]      w_head;

    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_one;
    endfunction

    // Credits in flight plus stored words must never exceed the FIFO size,
    // which is what makes data_tx_ready_o safe without a full check.
    assign w_outstanding = {1'b0, r_pending} + {1'b0, r_count};

    assign data_tx_req_o      = cfg_en_i & (w_outstanding < c_depth);
    assign data_tx_ready_o    = (r_pending != '0);
    assign data_tx_datasize_o = cfg_datasize_i;

    assign w_grant  = data_tx_req_o & data_tx_gnt_i;
    assign w_accept = data_tx_valid_i & data_tx_ready_o;
    assign w_drop   = data_tx_valid_i & ~data_tx_ready_o;
    assign w_tag_in = (cfg_datasize_i == 2'd3) ? 2'd2 : cfg_datasize_i;

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_last_idx = 2'd3;
        case (r_tag[r_rd_ptr])
            2'd0:    w_last_idx = 2'd0;
            2'd1:    w_last_idx = 2'd1;
            default: w_last_idx = 2'd3;
        endcase
    end

    assign byte_valid_o = (r_count != '0);
    assign byte_o       = byte_valid_o ? w_head[{r_byte_idx, 3'b000} +: 8] : 8'h00;
    assign w_byte_take  = byte_valid_o & byte_ready_i;
    assign w_last_byte  = (r_byte_idx == w_last_idx);
    assign w_pop        = w_byte_take & w_last_byte;

    assign busy_o = (r_pending != '0) | (r_count != '0);
    assign err_o  = r_err;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pending  <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_byte_idx <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            case ({w_grant, w_accept})
                2'b10:   r_pending <= r_pending + c_cnt_one;
                2'b01:   r_pending <= r_pending - c_cnt_one;
                default: r_pending <= r_pending;
            endcase

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            if (w_accept) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end

            if (w_pop) begin
                r_rd_ptr   <= f_ptr_inc(r_rd_ptr);
                r_byte_idx <= 2'd0;
            end else if (w_byte_take) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end

            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage is not reset: entries are only visible once r_count covers them.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= data_tx_i;
            r_tag[r_wr_ptr] <= w_tag_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udma_tx_dp_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_udma_tx_dp_unpacker
// Brief    : Directed table-driven bench for udma_tx_dp_unpacker (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_udma_tx_dp_unpacker;

    logic        clk = 1'b0;
    logic        r_rstn;
    logic        r_en;
    logic [1:0]  r_size;
    logic        r_gnt;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_bready;
    logic        w_req;
    logic [1:0]  w_dsize;
    logic        w_ready;
    logic [7:0]  w_byte;
    logic        w_bv;
    logic        w_busy;
    logic        w_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        en;
        logic [1:0]  size;
        logic        gnt;
        logic        valid;
        logic [31:0] data;
        logic        bready;
        logic        req;
        logic        ready;
        logic        bv;
        logic [7:0]  byt;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t vq[$];
    logic [31:0] words [2];

    udma_tx_dp_unpacker #(.DEPTH(2), .DW(32)) dut (
        .clk_i              (clk),
        .rstn_i             (r_rstn),
        .cfg_en_i           (r_en),
        .cfg_datasize_i     (r_size),
        .data_tx_req_o      (w_req),
        .data_tx_gnt_i      (r_gnt),
        .data_tx_datasize_o (w_dsize),
        .data_tx_i          (r_data),
        .data_tx_valid_i    (r_valid),
        .data_tx_ready_o    (w_ready),
        .byte_o             (w_byte),
        .byte_valid_o       (w_bv),
        .byte_ready_i       (r_bready),
        .busy_o             (w_busy),
        .err_o              (w_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [1:0] size, input logic gnt, input logic valid,
                       input logic [31:0] data, input logic bready, input logic req, input logic ready,
                       input logic bv, input logic [7:0] byt, input logic busy, input logic err);
        vq.push_back(vec_t'{en, size, gnt, valid, data, bready, req, ready, bv, byt, busy, err});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req"},   32'(w_req),   32'(0));
        chk({tag, ".ready"}, 32'(w_ready), 32'(0));
        chk({tag, ".bv"},    32'(w_bv),    32'(0));
        chk({tag, ".byte"},  32'(w_byte),  32'(0));
        chk({tag, ".busy"},  32'(w_busy),  32'(0));
        chk({tag, ".err"},   32'(w_err),   32'(0));
    endtask

    // Stall the byte side with grants always offered; counts grants taken.
    task automatic fill_two(output int grants);
        int credits;
        int wi;
        credits = 0;
        wi      = 0;
        grants  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            r_en     = 1'b1;
            r_size   = 2'd2;
            r_gnt    = 1'b1;
            r_bready = 1'b0;
            r_valid  = (credits > 0) && (wi < 2);
            r_data   = (wi < 2) ? words[wi] : 32'h0;
            #1;
            if (w_req && r_gnt) begin
                grants++;
                credits++;
            end
            if (r_valid && w_ready) begin
                credits--;
                wi++;
            end
        end
    endtask

    initial begin
        int grants;
        logic [31:0] w;

        words[0] = 32'hA0A1A2A3;
        words[1] = 32'hB0B1B2B3;

        r_rstn = 1'b0; r_en = 1'b0; r_size = 2'd0; r_gnt = 1'b0;
        r_data = 32'h0; r_valid = 1'b0; r_bready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        r_rstn = 1'b1;

        // en size gnt valid data bready | req ready bv byte busy err
        add(1, 2, 1, 0, 32'h0,        1,  1, 0, 0, 8'h00, 0, 0);
        add(0, 2, 0, 1, 32'h44332211, 1,  0, 1, 0, 8'h00, 1, 0);
        add(0, 2, 0, 0, 32'h0,        1,  0, 0, 1, 8'h11, 1, 0);
        add(0, 2, 0, 0, 32'h0,        1,  0, 0, 1, 8'h22, 1, 0);
        add(0, 2, 0, 0, 32'h0,        1,  0, 0, 1, 8'h33, 1, 0);
        add(0, 2, 0, 0, 32'h0,        1,  0, 0, 1, 8'h44, 1, 0);
        add(0, 2, 0, 0, 32'h0,        1,  0, 0, 0, 8'h00, 0, 0);
        // byte size, grant coincides with accept at one credit
        add(1, 0, 1, 0, 32'h0,        1,  1, 0, 0, 8'h00, 0, 0);
        add(1, 0, 1, 1, 32'hAAAAAA5A, 1,  1, 1, 0, 8'h00, 1, 0);
        add(0, 0, 0, 1, 32'hBBBBBB6B, 1,  0, 1, 1, 8'h5A, 1, 0);
        add(0, 0, 0, 0, 32'h0,        1,  0, 0, 1, 8'h6B, 1, 0);
        add(0, 0, 0, 0, 32'h0,        1,  0, 0, 0, 8'h00, 0, 0);
        // half-word size
        add(1, 1, 1, 0, 32'h0,        1,  1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 1, 32'h0000BEEF, 1,  0, 1, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 32'h0,        1,  0, 0, 1, 8'hEF, 1, 0);
        add(0, 1, 0, 0, 32'h0,        1,  0, 0, 1, 8'hBE, 1, 0);
        add(0, 1, 0, 0, 32'h0,        1,  0, 0, 0, 8'h00, 0, 0);
        // size 3 behaves as a full word
        add(1, 3, 1, 0, 32'h0,        1,  1, 0, 0, 8'h00, 0, 0);
        add(0, 3, 0, 1, 32'hDDCCBBAA, 1,  0, 1, 0, 8'h00, 1, 0);
        add(0, 3, 0, 0, 32'h0,        1,  0, 0, 1, 8'hAA, 1, 0);
        add(0, 3, 0, 0, 32'h0,        1,  0, 0, 1, 8'hBB, 1, 0);
        add(0, 3, 0, 0, 32'h0,        1,  0, 0, 1, 8'hCC, 1, 0);
        add(0, 3, 0, 0, 32'h0,        1,  0, 0, 1, 8'hDD, 1, 0);
        add(0, 3, 0, 0, 32'h0,        1,  0, 0, 0, 8'h00, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            r_en = vq[i].en; r_size = vq[i].size; r_gnt = vq[i].gnt;
            r_valid = vq[i].valid; r_data = vq[i].data; r_bready = vq[i].bready;
            #1;
            chk($sformatf("v%0d.req", i),   32'(w_req),   32'(vq[i].req));
            chk($sformatf("v%0d.ready", i), 32'(w_ready), 32'(vq[i].ready));
            chk($sformatf("v%0d.bv", i),    32'(w_bv),    32'(vq[i].bv));
            chk($sformatf("v%0d.byte", i),  32'(w_byte),  32'(vq[i].byt));
            chk($sformatf("v%0d.busy", i),  32'(w_busy),  32'(vq[i].busy));
            chk($sformatf("v%0d.err", i),   32'(w_err),   32'(vq[i].err));
            chk($sformatf("v%0d.dsize", i), 32'(w_dsize), 32'(vq[i].size));
        end

        // Back-pressure: only DEPTH grants may be taken, nothing lost.
        fill_two(grants);
        chk("bp.grants", 32'(grants), 32'd2);
        chk("bp.req",    32'(w_req),  32'd0);
        chk("bp.busy",   32'(w_busy), 32'd1);
        chk("bp.err",    32'(w_err),  32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            r_en = 1'b0; r_gnt = 1'b1; r_valid = 1'b0; r_bready = 1'b1;
            #1;
            w = words[k / 4] >> (8 * (k % 4));
            chk($sformatf("bp.byte%0d", k),  32'(w_byte),  {24'h0, w[7:0]});
            chk($sformatf("bp.bv%0d", k),    32'(w_bv),    32'd1);
            chk($sformatf("bp.ready%0d", k), 32'(w_ready), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("bp.idle_bv",   32'(w_bv),   32'd0);
        chk("bp.idle_busy", 32'(w_busy), 32'd0);

        // Unsolicited valid: dropped, sticky error until reset.
        @(negedge clk);
        r_gnt = 1'b0; r_valid = 1'b1; r_data = 32'hDEADBEEF;
        #1;
        chk("err.ready", 32'(w_ready), 32'd0);
        chk("err.pre",   32'(w_err),   32'd0);
        @(negedge clk);
        r_valid = 1'b0;
        #1;
        chk("err.set",  32'(w_err),  32'd1);
        chk("err.bv",   32'(w_bv),   32'd0);
        chk("err.busy", 32'(w_busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("err.sticky", 32'(w_err), 32'd1);
        @(negedge clk);
        r_rstn = 1'b0;
        #1;
        chk("err.clr", 32'(w_err), 32'd0);
        @(negedge clk);
        r_rstn = 1'b1;

        // Reset with two stored words and the head partially unpacked.
        fill_two(grants);
        @(negedge clk);
        r_en = 1'b0; r_gnt = 1'b0; r_bready = 1'b1;
        #1;
        chk("mid.byte0", 32'(w_byte), 32'hA3);
        @(negedge clk);
        r_bready = 1'b0;
        #1;
        chk("mid.byte1", 32'(w_byte), 32'hA2);
        r_rstn = 1'b0;
        #1;
        chk_reset_outputs("mid.rst");
        @(negedge clk);
        r_rstn = 1'b1;
        r_bready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mid.post%0d.bv", k),   32'(w_bv),   32'd0);
            chk($sformatf("mid.post%0d.byte", k), 32'(w_byte), 32'd0);
            chk($sformatf("mid.post%0d.busy", k), 32'(w_busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
